// File: rtl/md_issue_ctrl_if.sv
// Handshake between the E-stage issue controller and the multiply/divide unit:
// Start, op and operands go out; HI/LO and the unit's busy flag come back.
interface md_issue_ctrl_if;
    logic        md_start;
    logic [2:0]  md_op;
    logic [31:0] md_data1;
    logic [31:0] md_data2;
    logic [31:0] md_hi;
    logic [31:0] md_lo;
    logic        md_busy;

    modport master (
        output md_start,
        output md_op,
        output md_data1,
        output md_data2,
        input  md_hi,
        input  md_lo,
        input  md_busy
    );

    modport slave (
        input  md_start,
        input  md_op,
        input  md_data1,
        input  md_data2,
        output md_hi,
        output md_lo,
        output md_busy
    );
endinterface

// File: rtl/md_issue_ctrl.sv
// E-stage issue/hazard controller for the multiply/divide unit: drives Start, mirrors the
// unit's countdown for the D-stage stall, returns mfhi/mflo data. Optional: MD_BUSY_CHECK_EN.
module md_issue_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   e_valid,
    input  logic [2:0]             e_md_op,
    input  logic                   e_is_md,
    input  logic [31:0]            e_rs,
    input  logic [31:0]            e_rt,
    input  logic                   d_is_md,
    md_issue_ctrl_if.master        md,
    output logic                   stall_d,
    output logic [31:0]            e_mdout,
    output logic                   busy,
    output logic                   md_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] count_r;
    logic             err_r;

    logic             issue_s;
    logic             div0_s;
    logic             run_s;
    logic             start_s;
    logic             viol_s;
    logic             busy_s;
    logic             busy_mis_s;
    logic             err_set_s;
    logic [CNT_W-1:0] load_s;

    // Countdown preload: divides take DIV_LAT cycles after Start, multiplies MULT_LAT.
    function automatic logic [CNT_W-1:0] op_latency(input logic is_div);
        logic [CNT_W-1:0] lat_v;
        if (is_div) begin
            lat_v = CNT_W'(DIV_LAT);
        end else begin
            lat_v = CNT_W'(MULT_LAT);
        end
        return lat_v;
    endfunction

    // Issue decode, hazard detection and error sources.
    always_comb begin
        issue_s = e_valid & e_is_md;
        div0_s  = e_md_op[1] & (e_rt == 32'd0);
        run_s   = (count_r != {CNT_W{1'b0}});
        start_s = issue_s & ~e_md_op[2] & ~run_s & ~div0_s;
        // Anything but mfhi/mflo reaching E while the unit is busy means stall_d was ignored.
        viol_s  = issue_s & ~(e_md_op[2] & e_md_op[1]) & run_s;
        busy_s  = start_s | run_s;
`ifdef MD_BUSY_CHECK_EN
        busy_mis_s = busy_s ^ md.md_busy;
`else
        busy_mis_s = 1'b0;
`endif
        err_set_s = viol_s | busy_mis_s;
        load_s    = op_latency(e_md_op[1]);
    end

    // Unit-facing outputs, stall and mfhi/mflo read-back.
    always_comb begin
        md.md_start = start_s;
        // 111 is a no-op to the unit, so an idle E stage never writes HI/LO.
        if (issue_s) begin
            md.md_op = e_md_op;
        end else begin
            md.md_op = 3'b111;
        end
        md.md_data1 = e_rs;
        md.md_data2 = e_rt;
        busy        = busy_s;
        stall_d     = d_is_md & busy_s;
        md_err      = err_r;
        e_mdout     = 32'h0000_0000;
        if (e_is_md) begin
            case (e_md_op)
                3'b110:  e_mdout = md.md_hi;
                3'b111:  e_mdout = md.md_lo;
                default: e_mdout = 32'h0000_0000;
            endcase
        end else begin
            e_mdout = 32'h0000_0000;
        end
    end

    // IDLE/RUN countdown mirroring the unit, plus the sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            count_r <= {CNT_W{1'b0}};
            err_r   <= 1'b0;
        end else begin
            err_r <= err_r | err_set_s;
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        count_r <= load_s;
                        state_r <= ST_RUN;
                    end else begin
                        count_r <= {CNT_W{1'b0}};
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    count_r <= count_r - CNT_W'(1);
                    if (count_r == CNT_W'(1)) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    count_r <= {CNT_W{1'b0}};
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed plus randomized bench for md_issue_ctrl with a behavioural md unit and a
// cycle-indexed reference model of Start/busy/stall/HI/LO/error behaviour.
module tb_md_issue_ctrl;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        e_valid = 1'b0;
    logic [2:0]  e_md_op = 3'b000;
    logic        e_is_md = 1'b0;
    logic [31:0] e_rs = 32'h0;
    logic [31:0] e_rt = 32'h0;
    logic        d_is_md = 1'b0;
    logic        stall_d;
    logic [31:0] e_mdout;
    logic        busy;
    logic        md_err;

    md_issue_ctrl_if md_if ();

    md_issue_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .e_valid (e_valid),
        .e_md_op (e_md_op),
        .e_is_md (e_is_md),
        .e_rs    (e_rs),
        .e_rt    (e_rt),
        .d_is_md (d_is_md),
        .md      (md_if),
        .stall_d (stall_d),
        .e_mdout (e_mdout),
        .busy    (busy),
        .md_err  (md_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // HI/LO arithmetic of the unit: {hi, lo}; div/divu give lo = quotient, hi = remainder.
    function automatic logic [63:0] md_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (op)
            3'b000:  return $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            3'b001:  return {32'h0, a} * {32'h0, b};
            3'b010:  return (b == 32'h0) ? 64'h0 : {sa % sb, sa / sb};
            3'b011:  return (b == 32'h0) ? 64'h0 : {a % b, a / b};
            default: return 64'h0;
        endcase
    endfunction

    // Behavioural md unit responding to the DUT's Start/op.
    logic [31:0] u_hi = 32'h0;
    logic [31:0] u_lo = 32'h0;
    int          u_left = 0;
    logic        ovr_en = 1'b0;
    logic        ovr_val = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            u_left <= 0;
        end else if (md_if.md_start) begin
            {u_hi, u_lo} <= md_calc(md_if.md_op, md_if.md_data1, md_if.md_data2);
            u_left <= md_if.md_op[1] ? DIV_LAT : MULT_LAT;
        end else if (u_left != 0) begin
            u_left <= u_left - 1;
        end else if (md_if.md_op == 3'b100) begin
            u_hi <= md_if.md_data1;
        end else if (md_if.md_op == 3'b101) begin
            u_lo <= md_if.md_data1;
        end
    end

    assign md_if.md_hi   = u_hi;
    assign md_if.md_lo   = u_lo;
    assign md_if.md_busy = ovr_en ? ovr_val : (md_if.md_start | (u_left != 0));

    // Reference state: last busy cycle index, architectural HI/LO, sticky error.
    int          busy_until = -1;
    logic [31:0] r_hi = 32'h0;
    logic [31:0] r_lo = 32'h0;
    logic        r_err = 1'b0;
    int          stall_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One E-stage cycle: drive at negedge, check combinational outputs, advance reference at posedge.
    task automatic step(input logic v, input logic [2:0] op, input logic ismd,
                        input logic [31:0] rs, input logic [31:0] rt, input logic dmd);
        int          c;
        logic        issue;
        logic        run;
        logic        start;
        logic        bz;
        logic        viol;
        logic [2:0]  eop;
        logic [31:0] mdout;
        @(negedge clk);
        e_valid = v;
        e_md_op = op;
        e_is_md = ismd;
        e_rs    = rs;
        e_rt    = rt;
        d_is_md = dmd;
        #1;
        c     = cyc;
        issue = v & ismd;
        run   = (c <= busy_until);
        start = issue && (op < 3'd4) && !run && !(op[1] && (rt == 32'h0));
        bz    = start || run;
        viol  = issue && (op < 3'd6) && run;
        eop   = issue ? op : 3'b111;
        mdout = !ismd ? 32'h0 : (op == 3'b110) ? r_hi : (op == 3'b111) ? r_lo : 32'h0;
        chk("md_start", {31'h0, md_if.md_start}, {31'h0, start});
        chk("md_op", {29'h0, md_if.md_op}, {29'h0, eop});
        chk("md_data1", md_if.md_data1, rs);
        chk("md_data2", md_if.md_data2, rt);
        chk("busy", {31'h0, busy}, {31'h0, bz});
        chk("stall_d", {31'h0, stall_d}, {31'h0, dmd & bz});
        chk("e_mdout", e_mdout, mdout);
        chk("md_err", {31'h0, md_err}, {31'h0, r_err});
        if (stall_d === 1'b1) stall_cnt++;
        @(posedge clk);
        if (start) begin
            busy_until   = c + (op[1] ? DIV_LAT : MULT_LAT);
            {r_hi, r_lo} = md_calc(op, rs, rt);
        end else if (issue && !run && op == 3'b100) begin
            r_hi = rs;
        end else if (issue && !run && op == 3'b101) begin
            r_lo = rs;
        end
        if (viol) r_err = 1'b1;
`ifdef MD_BUSY_CHECK_EN
        if (ovr_en && (ovr_val !== bz)) r_err = 1'b1;
`endif
    endtask

    task automatic idle(input int n, input logic dmd);
        for (int i = 0; i < n; i++) step(1'b0, 3'b000, 1'b0, 32'h0, 32'h0, dmd);
    endtask

    // Asynchronous reset away from the clock edge, checked immediately.
    task automatic do_reset();
        @(negedge clk);
        e_valid = 1'b0;
        e_is_md = 1'b0;
        d_is_md = 1'b1;
        #1;
        chk("pre_rst_busy", {31'h0, busy}, {31'h0, (cyc <= busy_until)});
        #1 reset = 1'b0;
        #1;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_stall", {31'h0, stall_d}, 32'h0);
        chk("rst_err", {31'h0, md_err}, 32'h0);
        chk("rst_start", {31'h0, md_if.md_start}, 32'h0);
        busy_until = -1;
        r_err = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
    endtask

    initial begin
        logic        rv;
        logic        rm;
        logic [2:0]  rop;
        logic [31:0] rrt;

        d_is_md = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("init_busy", {31'h0, busy}, 32'h0);
        chk("init_stall", {31'h0, stall_d}, 32'h0);
        chk("init_err", {31'h0, md_err}, 32'h0);

        // Reset mid-RUN with count = 3
        step(1'b1, 3'b000, 1'b1, 32'd3, 32'd5, 1'b1);
        idle(2, 1'b1);
        do_reset();

        // Signed multiply, 6 stall cycles, then mflo/mfhi
        stall_cnt = 0;
        step(1'b1, 3'b000, 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 1'b1);
        idle(7, 1'b1);
        chk("mult_stall_cycles", stall_cnt, 32'd6);
        step(1'b1, 3'b111, 1'b1, 32'h0, 32'h0, 1'b0);
        #1 chk("mult_mflo", e_mdout, 32'hFFFF_FFF2);
        step(1'b1, 3'b110, 1'b1, 32'h0, 32'h0, 1'b0);
        #1 chk("mult_mfhi", e_mdout, 32'hFFFF_FFFF);

        // divu 100/7 with and without a HI/LO-class instruction in D
        stall_cnt = 0;
        step(1'b1, 3'b011, 1'b1, 32'd100, 32'd7, 1'b1);
        idle(12, 1'b1);
        chk("divu_stall_cycles", stall_cnt, 32'd11);
        step(1'b1, 3'b111, 1'b1, 32'h0, 32'h0, 1'b0);
        #1 chk("divu_mflo", e_mdout, 32'd14);
        step(1'b1, 3'b110, 1'b1, 32'h0, 32'h0, 1'b0);
        #1 chk("divu_mfhi", e_mdout, 32'd2);
        stall_cnt = 0;
        step(1'b1, 3'b011, 1'b1, 32'd100, 32'd7, 1'b0);
        idle(12, 1'b0);
        chk("divu_nostall", stall_cnt, 32'd0);

        // Divide by zero leaves HI/LO alone and raises nothing
        step(1'b1, 3'b100, 1'b1, 32'h0000_1234, 32'h0, 1'b0);
        step(1'b1, 3'b010, 1'b1, 32'd55, 32'h0, 1'b1);
        #1 chk("div0_start", {31'h0, md_if.md_start}, 32'h0);
        chk("div0_busy", {31'h0, busy}, 32'h0);
        step(1'b1, 3'b110, 1'b1, 32'h0, 32'h0, 1'b1);
        #1 chk("div0_mfhi", e_mdout, 32'h0000_1234);
        chk("div0_err", {31'h0, md_err}, 32'h0);

        // mtlo forced in during mult RUN at count = 2
        stall_cnt = 0;
        step(1'b1, 3'b001, 1'b1, 32'd9, 32'd9, 1'b1);
        idle(3, 1'b1);
        step(1'b1, 3'b101, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b1);
        #1 chk("viol_start", {31'h0, md_if.md_start}, 32'h0);
        idle(4, 1'b1);
        chk("viol_stall_cycles", stall_cnt, 32'd6);
        chk("viol_err", {31'h0, md_err}, 32'h1);
        idle(3, 1'b0);
        chk("viol_err_sticky", {31'h0, md_err}, 32'h1);
        do_reset();
        #1 chk("viol_err_cleared", {31'h0, md_err}, 32'h0);

        // md_busy disagreeing with the internal count (count = 4)
        step(1'b1, 3'b000, 1'b1, 32'd2, 32'd3, 1'b0);
        idle(1, 1'b0);
        ovr_en = 1'b1;
        ovr_val = 1'b0;
        idle(1, 1'b0);
        #1 ovr_en = 1'b0;
`ifdef MD_BUSY_CHECK_EN
        chk("busy_check_err", {31'h0, md_err}, 32'h1);
`else
        chk("busy_check_err", {31'h0, md_err}, 32'h0);
`endif
        idle(4, 1'b0);
        do_reset();

        // Randomized traffic, mostly respecting the stall, reset between blocks
        for (int blk = 0; blk < 3; blk++) begin
            for (int i = 0; i < 120; i++) begin
                rv  = ($urandom_range(0, 3) != 0);
                rm  = ($urandom_range(0, 3) != 0);
                rop = 3'($urandom_range(0, 7));
                rrt = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
                if ((cyc + 1 <= busy_until) && ($urandom_range(0, 15) != 0)) begin
                    rop = {2'b11, 1'($urandom_range(0, 1))};
                end
                step(rv, rop, rm, $urandom, rrt, 1'($urandom_range(0, 1)));
            end
            do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
E-stage issue and hazard controller that sits directly upstream of the multiply/divide unit.
- Decodes E-stage HI/LO-class instructions and drives the md unit's Start, md_op and operand inputs.
- Mirrors the unit's countdown to produce the D-stage stall.
- Returns mfhi/mflo read data to the E-stage result mux.

Parameters:
MULT_LAT, 5, busy cycles after the Start cycle for mult/multu.
DIV_LAT, 10, busy cycles after the Start cycle for div/divu.
CNT_W, 4, countdown width; must satisfy 2^CNT_W > max(MULT_LAT, DIV_LAT).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low; 0 clears all state
e_valid  input  1  E-stage holds a valid (non-bubble) instruction
e_md_op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 mfhi, 111 mflo
e_is_md  input  1  E-stage instruction is HI/LO-class (qualifies e_md_op)
e_rs  input  32  forwarded rs value
e_rt  input  32  forwarded rt value
d_is_md  input  1  D-stage instruction is HI/LO-class
md_hi  input  32  hi from md unit
md_lo  input  32  lo from md unit
md_busy  input  1  busy from md unit (used only by optional check)
md_start  output  1  Start to md unit
md_op  output  3  md_op to md unit
md_data1  output  32  Data1 to md unit
md_data2  output  32  Data2 to md unit
stall_d  output  1  freeze F/D, insert bubble into E
e_mdout  output  32  mfhi/mflo result for E-stage result mux
busy  output  1  internal busy (count != 0 or md_start)
md_err  output  1  sticky protocol/consistency error

Behaviour:
- Issue condition: issue = e_valid & e_is_md.
- Start (combinational):
  - md_start = issue & ~e_md_op[2] & (count == 0) & ~div0.
  - div0 = e_md_op[1] & (e_rt == 0).
- Operand and op outputs:
  - md_op = e_md_op when issue, else 3'b111. 111 is a no-op encoding for the unit, so no stray mthi/mtlo writes occur.
  - md_data1 = e_rs; md_data2 = e_rt (pass-through).
- States: IDLE (count == 0) and RUN (count != 0).
  - IDLE -> RUN on the clk edge with md_start = 1: count <= MULT_LAT for op 00x, DIV_LAT for op 01x.
  - RUN: count decrements by 1 each edge; RUN -> IDLE on the edge where count goes 1 -> 0.
- Busy timing:
  - busy = md_start | (count != 0).
  - For mult: busy is high in the Start cycle plus the 5 following cycles (6 total); for div: 11 total.
- Stall: stall_d = d_is_md & busy.
  - Non-MD instructions in D never stall.
  - stall_d deasserts in the first cycle where count == 0 and md_start == 0.
- mfhi/mflo: e_mdout = md_hi for op 110, md_lo for op 111, else 0. Never issued while busy; the stall guarantees this.
- mthi/mtlo:
  - Pass through with md_start = 0 and no countdown load.
  - Allowed only in IDLE; if issued in RUN, md_err is set.
- Divide by zero:
  - div/divu with e_rt == 0: Start is suppressed, count stays 0, no stall; HI/LO are left unchanged.
  - md_err is not set.
- Protocol violations: any issue of op 0xx, 100 or 101 while count != 0 (only possible if upstream ignores stall_d):
  - md_start is forced 0 and the op is dropped; count continues undisturbed.
  - md_err <= 1 (sticky until reset).
- Reset:
  - Asynchronous active-low reset at any time, including mid-RUN, sets count = 0 and md_err = 0; combinational outputs follow.
  - After reset release the block is IDLE, busy = 0, stall_d = 0.

Optional Feature:
MD_BUSY_CHECK_EN
- Defined: every clk edge compares the internal busy against md_busy; any mismatch sets md_err (sticky).
- Undefined: md_busy is ignored; md_err reflects protocol violations only.

Test Plan:
1. Reset low mid-RUN (count = 3) -> immediately count = 0, busy = 0, stall_d = 0, md_err = 0.
2. mult e_rs = 0x00000007, e_rt = 0xFFFFFFFE, d_is_md = 1 held -> md_start high 1 cycle, md_op = 000, stall_d high 6 cycles; the following mflo gets e_mdout = 0xFFFFFFF2 and mfhi gets 0xFFFFFFFF.
3. divu 100 / 7 -> stall_d high 11 cycles with d_is_md = 1; then mflo -> 14 and mfhi -> 2. With d_is_md = 0 throughout, stall_d stays 0.
4. div with e_rt = 0 -> md_start = 0, busy = 0, HI/LO unchanged (prior 0x1234 still read by mfhi), md_err = 0.
5. Force mtlo issue during mult RUN (count = 2) -> md_start = 0, count still reaches 0 on schedule, md_err = 1 and stays 1 until reset.
6. With MD_BUSY_CHECK_EN, drive md_busy = 0 while internal count = 4 -> md_err = 1 on the next edge. Without the macro -> md_err stays 0.
